// File: rtl/branch_cond_eval.sv
// branch_cond_eval: NZCV flag register, pending flag-writer tracking and branch condition resolution.
// Optional early resolution from flag_in on the final writeback: define BRANCH_COND_BYPASS_EN.
module branch_cond_eval #(
  parameter int TAG_W  = 4,
  parameter int PEND_W = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [3:0]       flag_in,
  input  logic             flag_we,
  input  logic             flag_issue,
  output logic             pend_full,
  input  logic             br_valid,
  output logic             br_ready,
  input  logic [3:0]       br_cond,
  input  logic [TAG_W-1:0] br_tag,
  output logic             res_valid,
  input  logic             res_ready,
  output logic             res_taken,
  output logic [TAG_W-1:0] res_tag,
  output logic [3:0]       flags_q
);
  typedef enum logic [1:0] {IDLE, WAIT, HOLD} state_t;
  state_t            r_state;
  logic [3:0]        r_flags;
  logic [PEND_W-1:0] r_pend;
  logic [3:0]        r_cond;
  logic [TAG_W-1:0]  r_tag;
  logic [TAG_W-1:0]  r_res_tag;
  logic              r_taken;
  logic              w_idle;
  logic              w_pend_zero;
  logic              w_bypass;
  logic              w_resolve;
  logic              w_taken;
  logic [3:0]        w_cond;
  logic [TAG_W-1:0]  w_tag;
  logic [PEND_W-1:0] w_pend_nxt;
  // Odd codes are the negation of the preceding even code; 14/15 pair AL/NV on a constant 1.
  function automatic logic eval(input logic [3:0] c, input logic [3:0] f);
    logic n, z, cy, v;
    logic [7:0] base;
    {n, z, cy, v} = f;
    base = {1'b1, ~z & ~(n ^ v), ~(n ^ v), cy & ~z, v, n, cy, z};
    return base[c[3:1]] ^ c[0];
  endfunction
`ifdef BRANCH_COND_BYPASS_EN
  assign w_bypass = (r_pend == PEND_W'(1)) && flag_we && !flag_issue;
`else
  assign w_bypass = 1'b0;
`endif
  assign w_idle      = r_state == IDLE;
  assign w_pend_zero = r_pend == '0;
  assign w_resolve   = w_pend_zero | w_bypass;
  assign w_cond      = w_idle ? br_cond : r_cond;
  assign w_tag       = w_idle ? br_tag : r_tag;
  assign w_taken     = eval(w_cond, w_pend_zero ? r_flags : flag_in);
  assign pend_full   = r_pend == '1;
  assign br_ready    = w_idle;
  assign res_valid   = r_state == HOLD;
  assign res_taken   = r_taken;
  assign res_tag     = r_res_tag;
  assign flags_q     = r_flags;
  always_comb
    w_pend_nxt = (flag_issue && !flag_we && !pend_full)  ? r_pend + PEND_W'(1) :
                 (flag_we && !flag_issue && !w_pend_zero) ? r_pend - PEND_W'(1) : r_pend;
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= IDLE;
      r_flags   <= '0;
      r_pend    <= '0;
      r_cond    <= '0;
      r_tag     <= '0;
      r_res_tag <= '0;
      r_taken   <= 1'b0;
    end else begin
      if (flag_we) r_flags <= flag_in;
      r_pend <= w_pend_nxt;
      case (r_state)
        IDLE: if (br_valid) begin
          r_cond  <= br_cond;
          r_tag   <= br_tag;
          r_state <= w_resolve ? HOLD : WAIT;
          if (w_resolve) begin
            r_taken   <= w_taken;
            r_res_tag <= w_tag;
          end
        end
        WAIT: if (w_resolve) begin
          r_taken   <= w_taken;
          r_res_tag <= w_tag;
          r_state   <= HOLD;
        end
        HOLD: if (res_ready) r_state <= IDLE;
        default: r_state <= IDLE;
      endcase
    end
  end
endmodule
